// File: rtl/gates4a_sweep_pkg.sv
// Shared constants, state encodings and helpers for the gates4a sweep sequencer.
package gates4a_sweep_pkg;

  // Number of input patterns, pattern width and gate output width
  localparam int unsigned NPAT = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned YW   = 6;
  localparam int unsigned PW   = 8;

  // FSM encodings kept as plain constants for compatibility with older tools
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Dwell counter width: ceil(log2(dwell)), never less than one bit
  function automatic int unsigned ctr_width(input int unsigned dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/gates4a_sweep_if.sv
// Control, pattern and result-store signals between the sweep sequencer and its users.
interface gates4a_sweep_if;
  import gates4a_sweep_pkg::*;

  logic          start;
  logic          step;
  logic          cont;
  logic [YW-1:0] y;
  logic [AW-1:0] a;
  logic          busy;
  logic          done;
  logic [PW-1:0] passes;
  logic [AW-1:0] rd_addr;
  logic [YW-1:0] rd_data;

  // Master drives control, gate output and read address; slave is the sequencer
  modport master (
    output start, step, cont, y, rd_addr,
    input  a, busy, done, passes, rd_data
  );

  modport slave (
    input  start, step, cont, y, rd_addr,
    output a, busy, done, passes, rd_data
  );

endinterface

// File: rtl/gates4a_dwell_ctr.sv
// Dwell counter: counts cycles a pattern is held and flags the last one.
module gates4a_dwell_ctr
  import gates4a_sweep_pkg::*;
#(
  parameter int unsigned DWELL = 100
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic load0,
  output logic last
);

  localparam int unsigned   CW      = ctr_width(DWELL);
  localparam logic [CW-1:0] LastVal = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // With DWELL=1 LastVal is 0, so the counter never leaves 0 and every enabled cycle is last
  assign last = en && (cnt_q == LastVal);

  // Next count: clear on load or wrap, otherwise advance while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (load0) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gates4a_sweep.sv
// Stimulus sequencer and result capture for the gates4a reduction-gate block.
// Steps a through all patterns, holds each for DWELL cycles and stores y on the last one.
module gates4a_sweep
  import gates4a_sweep_pkg::*;
#(
  parameter int unsigned DWELL = 100
) (
  input logic            clk,
  input logic            clr,
  gates4a_sweep_if.slave bus
);

  localparam logic [AW-1:0] LastPat = AW'(NPAT - 1);
  localparam logic [PW-1:0] PassMax = '1;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] a_q, a_d;
  logic          cont_q, cont_d;
  logic [PW-1:0] passes_q, passes_d;
  logic [YW-1:0] mem_q [NPAT];
  logic [YW-1:0] rd_data_q;

  logic run;
  logic start_go;
  logic step_go;
  logic last;
  logic wr_en;

  assign run      = (state_q == StRun);
  assign start_go = bus.start && !run;
  // start has priority over step in the same cycle
  assign step_go  = bus.step && !run && !bus.start;

  gates4a_dwell_ctr #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk  (clk),
    .clr  (clr),
    .en   (run),
    .load0(start_go),
    .last (last)
  );

  // Next-state: sweep start, manual step, or end-of-dwell advance
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    cont_d   = cont_q;
    passes_d = passes_q;
    wr_en    = 1'b0;
    if (start_go) begin
      state_d = StRun;
      a_d     = '0;
      cont_d  = bus.cont;
    end else if (step_go) begin
      wr_en = 1'b1;
      a_d   = a_q + 1'b1;
    end else if (run && last) begin
      wr_en = 1'b1;
      if (a_q != LastPat) begin
        a_d = a_q + 1'b1;
      end else begin
        passes_d = (passes_q == PassMax) ? passes_q : passes_q + 1'b1;
        if (cont_q) begin
          a_d = '0;
        end else begin
          state_d = StDone;
        end
      end
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= StIdle;
      a_q      <= '0;
      cont_q   <= 1'b0;
      passes_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      cont_q   <= cont_d;
      passes_q <= passes_d;
    end
  end

  // Result store and registered read port; a same-cycle read sees the old entry
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NPAT; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[a_q] <= bus.y;
      end
      rd_data_q <= mem_q[bus.rd_addr];
    end
  end

  assign bus.a       = a_q;
  assign bus.busy    = run;
  assign bus.done    = (state_q == StDone);
  assign bus.passes  = passes_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_gates4a_sweep.sv
// Self-checking bench for gates4a_sweep: two instances (DWELL=4 and DWELL=1) driven by
// directed steps with randomized gaps and read orders, checked against a timing model.
module tb_gates4a_sweep;

  logic clk = 1'b0;
  logic clr;

  gates4a_sweep_if bus4 ();
  gates4a_sweep_if bus1 ();

  // Behavioural gate model: store entry k must read back k
  assign bus4.y = {2'b00, bus4.a};
  assign bus1.y = {2'b00, bus1.a};

  gates4a_sweep #(.DWELL(4)) u_dut4 (.clk(clk), .clr(clr), .bus(bus4));
  gates4a_sweep #(.DWELL(1)) u_dut1 (.clk(clk), .clr(clr), .bus(bus1));

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int          mem4_m [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic status(input bit sel1, input string tag, input int a_e, input int busy_e,
                        input int done_e, input int passes_e);
    if (sel1) begin
      check({tag, ".a"},      32'(bus1.a),      a_e);
      check({tag, ".busy"},   32'(bus1.busy),   busy_e);
      check({tag, ".done"},   32'(bus1.done),   done_e);
      check({tag, ".passes"}, 32'(bus1.passes), passes_e);
    end else begin
      check({tag, ".a"},      32'(bus4.a),      a_e);
      check({tag, ".busy"},   32'(bus4.busy),   busy_e);
      check({tag, ".done"},   32'(bus4.done),   done_e);
      check({tag, ".passes"}, 32'(bus4.passes), passes_e);
    end
  endtask

  task automatic rd(input bit sel1, input logic [3:0] addr, input int exp);
    if (sel1) bus1.rd_addr = addr;
    else      bus4.rd_addr = addr;
    tick();
    check($sformatf("rd%0d[%0d]", sel1 ? 1 : 4, addr),
          sel1 ? 32'(bus1.rd_data) : 32'(bus4.rd_data), exp);
  endtask

  // Read every entry of the DWELL=4 store in a random order
  task automatic readback4(input string tag);
    int idx [16];
    int j, tmp;
    for (int i = 0; i < 16; i++) idx[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = idx[i]; idx[i] = idx[j]; idx[j] = tmp;
    end
    for (int i = 0; i < 16; i++) begin
      bus4.rd_addr = 4'(idx[i]);
      tick();
      check($sformatf("%s[%0d]", tag, idx[i]), 32'(bus4.rd_data), mem4_m[idx[i]]);
    end
  endtask

  initial begin
    int ea;
    clr = 1'b1;
    bus4.start = 1'b0; bus4.step = 1'b0; bus4.cont = 1'b0; bus4.rd_addr = '0;
    bus1.start = 1'b0; bus1.step = 1'b0; bus1.cont = 1'b0; bus1.rd_addr = '0;
    for (int k = 0; k < 16; k++) mem4_m[k] = 0;

    // Reset for two cycles, then idle
    tick(); tick();
    clr = 1'b0;
    repeat (5) tick();
    status(0, "rst4", 0, 0, 0, 0);
    status(1, "rst1", 0, 0, 0, 0);
    check("rst4.rd_data", 32'(bus4.rd_data), 0);
    readback4("rst_mem4");
    rd(1, 4'($urandom_range(15, 0)), 0);

    // DWELL=4 single sweep; start+step together, then stray start/step while running
    repeat ($urandom_range(3, 0)) tick();
    bus4.cont = 1'b0; bus4.start = 1'b1; bus4.step = 1'b1;
    tick();
    bus4.start = 1'b0; bus4.step = 1'b0;
    for (int t = 0; t <= 67; t++) begin
      if (t < 64) status(0, $sformatf("sw4_t%0d", t), t / 4, 1, 0, 0);
      else        status(0, $sformatf("sw4_t%0d", t), 15, 0, 1, 1);
      bus4.start = (t == 9 || t == 30);
      bus4.step  = (t == 9 || t == 21);
      tick();
    end
    bus4.start = 1'b0; bus4.step = 1'b0;
    for (int k = 0; k < 16; k++) mem4_m[k] = k;
    readback4("sw4_mem");

    // DWELL=1 continuous sweep; cont changed after start must not matter
    bus1.cont = 1'b1; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0; bus1.cont = 1'b0;
    for (int t = 0; t <= 40; t++) begin
      status(1, $sformatf("sw1_t%0d", t), t % 16, 1, 0, t / 16);
      tick();
    end
    // Long enough for the pass counter to saturate
    repeat (4200 - 41) tick();
    status(1, "sw1_sat", 4200 % 16, 1, 0, 255);

    // Clear aborts the continuous sweep and wipes both stores
    clr = 1'b1;
    tick();
    clr = 1'b0;
    status(1, "clr1", 0, 0, 0, 0);
    status(0, "clr4", 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) mem4_m[k] = 0;
    readback4("clr_mem4");

    // Manual stepping from IDLE up to a=14, then three more across the wrap
    ea = 0;
    for (int s = 0; s < 17; s++) begin
      bus4.step = 1'b1;
      tick();
      bus4.step = 1'b0;
      mem4_m[ea] = ea;
      ea = (ea + 1) % 16;
      status(0, $sformatf("step%0d", s), ea, 0, 0, 0);
      repeat ($urandom_range(2, 0)) tick();
    end
    rd(0, 4'd14, 14);
    rd(0, 4'd15, 15);
    rd(0, 4'd0, 0);
    readback4("step_mem4");

    // Clear in the middle of a DWELL=4 sweep at a=7
    bus4.cont = 1'b0; bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int t = 0; t <= 28; t++) begin
      status(0, $sformatf("ab_t%0d", t), t / 4, 1, 0, 0);
      if (t < 28) tick();
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    status(0, "ab_clr", 0, 0, 0, 0);
    check("ab_clr.rd_data", 32'(bus4.rd_data), 0);
    for (int k = 0; k < 16; k++) mem4_m[k] = 0;
    rd(0, 4'd3, 0);
    readback4("ab_mem4");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gates4a_sweep.md
# gates4a_sweep

Upstream stimulus sequencer and result capture for the `gates4a` reduction-gate block. It steps the 4-bit input `a` through all 16 patterns, holding each for `DWELL` clock cycles. On the last dwell cycle it samples the 6-bit gate output `y` into a 16-entry result store. The store is readable by the board display or UART stage. It replaces hand-timed stimulus with a synthesizable, clocked sweep usable both on the board and in simulation.

## Interface
- `DWELL`, default 100: clock cycles each pattern is held; legal range 1..65535.
- `clk` in 1: system clock, rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse; begins a sweep from `a=0`. Ignored while `busy`.
- `step` in 1: one-cycle pulse; manual single-step. Honoured only when not `busy`.
- `cont` in 1: 1 = wrap 15->0 and sweep forever; 0 = stop after pattern 15. Sampled at `start`.
- `y` in 6: output of `gates4a`, driven combinationally from `a`.
- `a` out 4: pattern driven to `gates4a`; registered.
- `busy` out 1: high while a sweep is running.
- `done` out 1: high from the end of a non-continuous sweep until the next `start` or `clr`.
- `passes` out 8: count of completed sweeps since `clr`; saturates at 255.
- `rd_addr` in 4: result store read address.
- `rd_data` out 6: registered read data; `mem[rd_addr]` one cycle later.

## Operation
- States:
  - IDLE: reset state.
  - RUN: sweeping.
  - DONE: non-continuous sweep finished.
- Reset (`clr`=1 at an edge): `a`=0, `busy`=0, `done`=0, `passes`=0, `rd_data`=0, dwell counter=0, all 16 store entries=0, state=IDLE, latched `cont`=0.
- IDLE/DONE + `start`:
  - Next cycle: state=RUN, `a`=0, dwell counter=0, `busy`=1, `done`=0.
  - `cont` is latched.
- RUN, each cycle: the dwell counter increments. When it equals `DWELL-1` (the last cycle of the pattern):
  - `mem[a]<=y` and the counter clears.
  - If `a`<15: `a<=a+1`.
  - If `a`=15 and latched `cont`=1: `a<=0`, `passes` increments (saturating), state stays RUN.
  - If `a`=15 and latched `cont`=0: `passes` increments, state=DONE, `busy`=0, `done`=1, `a` holds 15.
- IDLE/DONE + `step` (and no `start`): `mem[a]<=y` and `a<=a+1` with 15->0 wrap. Nothing else changes; `passes` is unaffected.
- Simultaneous events:
  - `start` and `step` in the same cycle: `start` wins, `step` is dropped.
  - `start` or `step` while RUN: ignored.
  - `clr` with anything else: `clr` wins.
- `clr` mid-sweep: abort immediately to the reset values above. The partially filled store is cleared.
- The read port is independent of state. A read of an entry in the same cycle it is written returns the old value.

## Timing
- `start` at edge N: `a`=0 is visible after N+1. Pattern k is held for edges N+1+k·DWELL through N+(k+1)·DWELL.
- `y` is sampled DWELL-1 cycles after `a` changes. This leaves at least DWELL-1 cycles of settling (zero when DWELL=1; combinational path only).
- A full non-continuous sweep lasts 16·DWELL cycles from the first `a`=0 cycle. `done` rises on the edge after pattern 15's last dwell cycle.
- `rd_data` latency: 1 cycle.
- Dwell counter width: ceil(log2(DWELL)), minimum 1 bit. For DWELL=1 the counter is held at 0 and every RUN cycle is a sample cycle.

## Structure
- Shared header `gates4a_sweep_defs.vh`:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - `NPAT`=16;
  - `YW`=6.
- Sub-module `gates4a_dwell_ctr`: parameter `DWELL`; inputs `clk`, `clr`, `en`, `load0`; output `last`.
- The top holds the FSM, the `a` register, the `passes` counter and the 16×6 register-file store.

## Test plan
Benches use a behavioural `y = {2'b00, a}` so that store entry k must read k.
- `clr` for 2 cycles, then idle 5 cycles -> `a`=0, `busy`=0, `done`=0, `passes`=0, every `rd_data`=0.
- DWELL=4, `cont`=0, `start` pulse -> `a` steps 0..15 every 4 cycles; `done` rises 64 cycles after `a`=0; `passes`=1; `mem[k]`=k for all k.
- DWELL=1, `cont`=1, run 40 cycles -> `a` wraps 15->0 twice; `passes`=2; `done` stays 0.
- `start` and `step` in the same cycle from IDLE, then `start` repeated during RUN -> a single sweep from 0; second `start` has no effect on `a`.
- From IDLE at `a`=14, `step` ×3 -> `a`=15, 0, 1; `mem[14]`=14, `mem[15]`=15, `mem[0]`=0; `passes`=0.
- DWELL=4, `clr` asserted mid-sweep at `a`=7 -> next cycle all outputs at reset values; `mem[3]` reads 0.
